key_bus_master: RTL and testbench

//   Upstream bus master for the board-level peripheral harness (timer/UART over the 16-bit

---
 rtl/key_bus_master.sv | 112 +++++++++++
 tb/tb_key_bus_master.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/key_bus_master.sv
// Pushbutton-driven bus master: synchronizes and debounces two active-low keys and
// issues one single-cycle write or read strobe per debounced press.
module key_bus_master #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              keyWrN,
  input  logic              keyRdN,
  input  logic [1:0]        swAddr,
  input  logic [5:0]        swData,
  output logic [1:0]        busAddr,
  inout  tri   logic [15:0] busData,
  output logic              busEn,
  output logic              busWr,
  output logic [15:0]       rdData,
  output logic              rdValid,
  output logic              busy
);

  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned NKEYS  = 2;
  localparam int unsigned KEY_WR = 0;
  localparam int unsigned KEY_RD = 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WRITE   = 2'd1;
  localparam logic [1:0] READ    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [NKEYS-1:0] raw_c;
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] level;
  logic [NKEYS-1:0] press;
  logic [CNT_W-1:0] cnt [NKEYS];

  logic [1:0] state;
  logic [1:0] next_state_c;
  logic [5:0] wr_data;

  assign raw_c = {keyRdN, keyWrN};

  // 2-FF synchronizer, debounce counter and registered press pulse per key
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= '1;
      sync2 <= '1;
      level <= '1;
      press <= '0;
      for (int k = 0; k < NKEYS; k++) cnt[k] <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      for (int k = 0; k < NKEYS; k++) begin
        press[k] <= 1'b0;
        if (sync2[k] == level[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level[k] <= sync2[k];
          cnt[k]   <= '0;
          press[k] <= ~sync2[k];
        end else begin
          cnt[k] <= cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Next-state: write wins over a simultaneous read; presses outside IDLE are dropped
  always_comb begin
    next_state_c = state;
    case (state)
      IDLE: begin
        if (press[KEY_WR])      next_state_c = WRITE;
        else if (press[KEY_RD]) next_state_c = READ;
      end
      WRITE:   next_state_c = RELEASE;
      READ:    next_state_c = RELEASE;
      RELEASE: if (&level) next_state_c = IDLE;
      default: next_state_c = IDLE;
    endcase
  end

  // State and registered bus outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      busAddr <= '0;
      wr_data <= '0;
      busEn   <= 1'b0;
      busWr   <= 1'b0;
      rdData  <= '0;
      rdValid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= next_state_c;
      busEn   <= (next_state_c == WRITE) || (next_state_c == READ);
      busWr   <= (next_state_c == WRITE);
      busy    <= (next_state_c != IDLE);
      rdValid <= (state == READ);
      if ((state == IDLE) && (next_state_c != IDLE)) begin
        busAddr <= swAddr;
        wr_data <= swData;
      end
      if (state == READ) rdData <= busData;
    end
  end

  assign busData = (busEn && busWr) ? {10'b0, wr_data} : {16{1'bz}};

endmodule

// File: tb/tb_key_bus_master.sv
// Directed self-checking bench for key_bus_master: writes, reads, bounce filtering,
// key priority, long holds and reset during a held press.
module tb_key_bus_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        keyWrN;
  logic        keyRdN;
  logic [1:0]  swAddr;
  logic [5:0]  swData;
  logic [1:0]  busAddr;
  tri   [15:0] busData;
  logic        busEn;
  logic        busWr;
  logic [15:0] rdData;
  logic        rdValid;
  logic        busy;

  logic [15:0] slave_val;

  int n_checks = 0;
  int n_fail   = 0;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int rv_cnt = 0;
  logic [1:0]  last_wr_addr;
  logic [15:0] last_wr_data;
  logic [15:0] last_rd_bus;
  logic [15:0] last_rd_data;

  key_bus_master #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .keyWrN (keyWrN),
    .keyRdN (keyRdN),
    .swAddr (swAddr),
    .swData (swData),
    .busAddr(busAddr),
    .busData(busData),
    .busEn  (busEn),
    .busWr  (busWr),
    .rdData (rdData),
    .rdValid(rdValid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Slave answers reads combinationally
  assign busData = (busEn && !busWr) ? slave_val : 16'hzzzz;

  // Transaction monitor, sampled shortly after each rising edge
  always @(posedge clk) begin
    #1;
    if (busEn && busWr) begin
      wr_cnt++;
      last_wr_addr = busAddr;
      last_wr_data = busData;
    end
    if (busEn && !busWr) begin
      rd_cnt++;
      last_rd_bus = busData;
    end
    if (rdValid) begin
      rv_cnt++;
      last_rd_data = rdData;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int w0, r0, v0, lat;

  initial begin
    rstn = 1'b0; keyWrN = 1'b1; keyRdN = 1'b1;
    swAddr = '0; swData = '0; slave_val = 16'h0000;
    idle(3);
    check("rst_busEn",   32'(busEn),   32'd0);
    check("rst_busWr",   32'(busWr),   32'd0);
    check("rst_busAddr", 32'(busAddr), 32'd0);
    check("rst_rdData",  32'(rdData),  32'd0);
    check("rst_rdValid", 32'(rdValid), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    rstn = 1'b1;
    idle(3);

    // 1: single write, strobe 2 sync + 4 debounce (+1 FSM) cycles after the press
    w0 = wr_cnt; r0 = rd_cnt;
    swAddr = 2'd2; swData = 6'h2A;
    keyWrN = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busEn && lat == 0) lat = i;
    end
    check("t1_latency_6_or_7", 32'((lat == 6) || (lat == 7)), 32'd1);
    keyWrN = 1'b1;
    idle(20);
    check("t1_wr_count",  32'(wr_cnt - w0), 32'd1);
    check("t1_rd_count",  32'(rd_cnt - r0), 32'd0);
    check("t1_wr_addr",   32'(last_wr_addr), 32'd2);
    check("t1_wr_data",   32'(last_wr_data), 32'h002A);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: single read returning slave data
    w0 = wr_cnt; r0 = rd_cnt; v0 = rv_cnt;
    slave_val = 16'hBEEF; swAddr = 2'd1;
    keyRdN = 1'b0;
    idle(15);
    keyRdN = 1'b1;
    idle(20);
    check("t2_rd_count",  32'(rd_cnt - r0), 32'd1);
    check("t2_wr_count",  32'(wr_cnt - w0), 32'd0);
    check("t2_rd_bus",    32'(last_rd_bus), 32'hBEEF);
    check("t2_rv_pulses", 32'(rv_cnt - v0), 32'd1);
    check("t2_rv_data",   32'(last_rd_data), 32'hBEEF);
    check("t2_rdData",    32'(rdData), 32'hBEEF);
    check("t2_rdValid",   32'(rdValid), 32'd0);

    // 3a: bouncing contacts then a solid hold -> one write
    w0 = wr_cnt;
    swAddr = 2'd3; swData = 6'h01;
    keyWrN = 1'b0; idle(1); keyWrN = 1'b1; idle(2);
    keyWrN = 1'b0; idle(3); keyWrN = 1'b1; idle(1);
    keyWrN = 1'b0; idle(2); keyWrN = 1'b1; idle(1);
    keyWrN = 1'b0; idle(15);
    keyWrN = 1'b1; idle(20);
    check("t3_bounce_writes", 32'(wr_cnt - w0), 32'd1);
    check("t3_bounce_data",   32'(last_wr_data), 32'h0001);

    // 3b: isolated 3-cycle glitch -> nothing
    w0 = wr_cnt;
    keyWrN = 1'b0; idle(3); keyWrN = 1'b1; idle(20);
    check("t3_glitch_writes", 32'(wr_cnt - w0), 32'd0);
    check("t3_glitch_busy",   32'(busy), 32'd0);

    // 4: both keys together, held 1000 cycles -> exactly one write, no read
    w0 = wr_cnt; r0 = rd_cnt;
    swAddr = 2'd0; swData = 6'h3F;
    keyWrN = 1'b0; keyRdN = 1'b0;
    idle(1000);
    check("t4_busy_held", 32'(busy), 32'd1);
    keyWrN = 1'b1; keyRdN = 1'b1;
    idle(20);
    check("t4_writes", 32'(wr_cnt - w0), 32'd1);
    check("t4_reads",  32'(rd_cnt - r0), 32'd0);
    check("t4_data",   32'(last_wr_data), 32'h003F);
    check("t4_busy",   32'(busy), 32'd0);

    // 5: reset while parked in RELEASE with the key still held
    w0 = wr_cnt;
    swAddr = 2'd3; swData = 6'h15;
    keyWrN = 1'b0;
    idle(12);
    check("t5_first_write", 32'(wr_cnt - w0), 32'd1);
    check("t5_busy_release", 32'(busy), 32'd1);
    rstn = 1'b0;
    idle(1);
    check("t5_rst_busy",    32'(busy), 32'd0);
    check("t5_rst_busEn",   32'(busEn), 32'd0);
    check("t5_rst_rdData",  32'(rdData), 32'd0);
    check("t5_rst_busAddr", 32'(busAddr), 32'd0);
    idle(1);
    w0 = wr_cnt;
    rstn = 1'b1;
    idle(25);
    check("t5_rewrite_count", 32'(wr_cnt - w0), 32'd1);
    check("t5_rewrite_addr",  32'(last_wr_addr), 32'd3);
    check("t5_rewrite_data",  32'(last_wr_data), 32'h0015);
    keyWrN = 1'b1;
    idle(20);
    check("t5_final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
